// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, blank code, digit limit.
// Segment bit order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned MAX_DIGITS = 8;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    localparam logic [SEG_W-1:0] GLYPH_0 = 7'b1000000;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1111001;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0100100;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0110000;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'b0011001;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0010010;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0000010;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'b1111000;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0010000;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'b0000011;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'b1000110;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'b0100001;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'b0000110;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'b0001110;

    // Width of a counter that must hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble-to-glyph map; HEX_MODE selects A..F letters or blanks for 10..15.
module seg7_glyph
    import seg7_pkg::*;
#(
    parameter int unsigned HEX_MODE = 0
) (
    input  logic [NIBBLE_W-1:0] i_Nibble,
    output logic [SEG_W-1:0]    o_Glyph_c
);

    localparam logic HEX_EN = (HEX_MODE != 0);

    always_comb begin
        o_Glyph_c = SEG_BLANK;
        case (i_Nibble)
            4'h0: o_Glyph_c = GLYPH_0;
            4'h1: o_Glyph_c = GLYPH_1;
            4'h2: o_Glyph_c = GLYPH_2;
            4'h3: o_Glyph_c = GLYPH_3;
            4'h4: o_Glyph_c = GLYPH_4;
            4'h5: o_Glyph_c = GLYPH_5;
            4'h6: o_Glyph_c = GLYPH_6;
            4'h7: o_Glyph_c = GLYPH_7;
            4'h8: o_Glyph_c = GLYPH_8;
            4'h9: o_Glyph_c = GLYPH_9;
            4'hA: o_Glyph_c = HEX_EN ? GLYPH_A : SEG_BLANK;
            4'hB: o_Glyph_c = HEX_EN ? GLYPH_B : SEG_BLANK;
            4'hC: o_Glyph_c = HEX_EN ? GLYPH_C : SEG_BLANK;
            4'hD: o_Glyph_c = HEX_EN ? GLYPH_D : SEG_BLANK;
            4'hE: o_Glyph_c = HEX_EN ? GLYPH_E : SEG_BLANK;
            4'hF: o_Glyph_c = HEX_EN ? GLYPH_F : SEG_BLANK;
            default: o_Glyph_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with guard blanking and frame-based blink.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zero digits, digit 0 always shown).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned CLKS_PER_DIGIT = 25000,
    parameter int unsigned GUARD_CLKS     = 2,
    parameter int unsigned HEX_MODE       = 0,
    parameter int unsigned BLINK_FRAMES   = 250
) (
    input  logic                         i_Clk,
    input  logic                         i_Rst_n,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] i_Value,
    input  logic                         i_Load,
    input  logic                         i_Blink,
    output logic [SEG_W-1:0]             o_Segment,
    output logic [NUM_DIGITS-1:0]        o_Digit_En,
    output logic                         o_Frame_Done
);

    localparam int unsigned PW = cnt_width(CLKS_PER_DIGIT);
    localparam int unsigned IW = cnt_width(NUM_DIGITS);
    localparam int unsigned FW = cnt_width(BLINK_FRAMES);
    localparam int unsigned VW = NIBBLE_W * NUM_DIGITS;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_DIGIT - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRM_LAST   = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0] r_presc;
    logic [IW-1:0] r_idx;
    logic [FW-1:0] r_frm;
    logic          r_phase;
    logic [VW-1:0] r_disp;

    logic [PW-1:0]         w_presc_nxt;
    logic [IW-1:0]         w_idx_nxt;
    logic [FW-1:0]         w_frm_nxt;
    logic                  w_phase_nxt;
    logic [VW-1:0]         w_disp_nxt;
    logic                  w_presc_wrap;
    logic                  w_frame_wrap;
    logic [NIBBLE_W-1:0]   w_nibble;
    logic [SEG_W-1:0]      w_glyph;
    logic                  w_in_guard;
    logic                  w_blink_dark;
    logic                  w_lz_blank;
    logic                  w_fd_nxt;
    logic [NUM_DIGITS-1:0] w_onehot;

    // Counter next-state: prescaler, digit index, blink frame counter and phase.
    always_comb begin
        w_presc_wrap = (r_presc == PRESC_LAST);
        w_frame_wrap = w_presc_wrap && (r_idx == IDX_LAST);
        w_presc_nxt  = w_presc_wrap ? '0 : r_presc + PW'(1);
        w_idx_nxt    = r_idx;
        w_frm_nxt    = r_frm;
        w_phase_nxt  = r_phase;
        if (w_presc_wrap) begin
            w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        end
        if (w_frame_wrap) begin
            if (r_frm == FRM_LAST) begin
                w_frm_nxt   = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_frm_nxt = r_frm + FW'(1);
            end
        end
        w_disp_nxt = i_Load ? i_Value : r_disp;
    end

    // Outputs are registered from next-state values so they line up with the new count.
    always_comb begin
        w_nibble = w_disp_nxt[NIBBLE_W-1:0];
        for (int k = 1; k < int'(NUM_DIGITS); k++) begin
            if (w_idx_nxt == IW'(k)) begin
                w_nibble = w_disp_nxt[NIBBLE_W*k +: NIBBLE_W];
            end
        end
        w_in_guard   = (32'(w_presc_nxt) + 32'd1) <= GUARD_CLKS;
        w_blink_dark = i_Blink && !w_phase_nxt;
        w_fd_nxt     = (w_presc_nxt == PRESC_LAST) && (w_idx_nxt == IDX_LAST);
        w_onehot     = NUM_DIGITS'(1) << w_idx_nxt;
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Blank a zero digit when every digit above it is zero too; digit 0 is never blanked.
    always_comb begin
        logic v_upper_zero;
        v_upper_zero = 1'b1;
        w_lz_blank   = 1'b0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            v_upper_zero = v_upper_zero && (w_disp_nxt[NIBBLE_W*k +: NIBBLE_W] == 4'h0);
            if ((w_idx_nxt == IW'(k)) && v_upper_zero) begin
                w_lz_blank = 1'b1;
            end
        end
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    seg7_glyph #(
        .HEX_MODE (HEX_MODE)
    ) u_glyph (
        .i_Nibble  (w_nibble),
        .o_Glyph_c (w_glyph)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_frm        <= '0;
            r_phase      <= 1'b0;
            r_disp       <= '0;
            o_Segment    <= SEG_BLANK;
            o_Digit_En   <= '0;
            o_Frame_Done <= 1'b0;
        end else begin
            r_presc      <= w_presc_nxt;
            r_idx        <= w_idx_nxt;
            r_frm        <= w_frm_nxt;
            r_phase      <= w_phase_nxt;
            r_disp       <= w_disp_nxt;
            o_Frame_Done <= w_fd_nxt;
            if (w_in_guard || w_blink_dark) begin
                o_Segment  <= SEG_BLANK;
                o_Digit_En <= '0;
            end else begin
                o_Segment  <= w_lz_blank ? SEG_BLANK : w_glyph;
                o_Digit_En <= w_onehot;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (4 digits, 4 clocks/slot, 1 guard clock, 2 frames/blink half).
// Two instances share stimulus: HEX_MODE=0 and HEX_MODE=1.
module tb_seg7_scan_driver;

    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GF = 7'b0001110;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZU = BL;
`else
    localparam logic [6:0] ZU = G0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic        blink;
    logic [6:0]  seg,  seg_h;
    logic [3:0]  en,   en_h;
    logic        fd,   fd_h;

    int total = 0;
    int bad   = 0;
    int tb_p  = 0;
    int tb_i  = 0;
    int tb_f  = 0;
    bit tb_ph = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .CLKS_PER_DIGIT(4), .GUARD_CLKS(1), .HEX_MODE(0), .BLINK_FRAMES(2)
    ) dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Value(value), .i_Load(load), .i_Blink(blink),
        .o_Segment(seg), .o_Digit_En(en), .o_Frame_Done(fd)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(4), .CLKS_PER_DIGIT(4), .GUARD_CLKS(1), .HEX_MODE(1), .BLINK_FRAMES(2)
    ) dut_hex (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_Value(value), .i_Load(load), .i_Blink(blink),
        .o_Segment(seg_h), .o_Digit_En(en_h), .o_Frame_Done(fd_h)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (p=%0d i=%0d)", tag, obs, exp, tb_p, tb_i);
        end
    endtask

    // One clock; advance the expected slot/frame position.
    task automatic step();
        @(posedge clk);
        #1;
        if (tb_p == 3) begin
            tb_p = 0;
            if (tb_i == 3) begin
                tb_i = 0;
                if (tb_f == 1) begin
                    tb_f  = 0;
                    tb_ph = ~tb_ph;
                end else begin
                    tb_f++;
                end
            end else begin
                tb_i++;
            end
        end else begin
            tb_p++;
        end
    endtask

    // gv/hv hold expected glyphs {d3,d2,d1,d0} for the HEX_MODE=0 / HEX_MODE=1 instances.
    task automatic scan(input string tag, input int n, input logic [27:0] gv, input logic [27:0] hv);
        logic       lit;
        logic [3:0] en_exp;
        for (int c = 0; c < n; c++) begin
            step();
            lit    = (tb_p >= 1) && !(blink && !tb_ph);
            en_exp = lit ? (4'b0001 << tb_i) : 4'b0000;
            chk({tag, "_seg"},   32'(seg),   32'(lit ? gv[7*tb_i +: 7] : BL));
            chk({tag, "_en"},    32'(en),    32'(en_exp));
            chk({tag, "_fd"},    32'(fd),    32'((tb_p == 3) && (tb_i == 3)));
            chk({tag, "_hseg"},  32'(seg_h), 32'(lit ? hv[7*tb_i +: 7] : BL));
            chk({tag, "_hen"},   32'(en_h),  32'(en_exp));
        end
    endtask

    initial begin
        int lit_cnt;
        int fd_cnt;
        int guard;

        rst_n = 1'b0;
        value = 16'h0000;
        load  = 1'b0;
        blink = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg",  32'(seg),   32'(BL));
        chk("rst_en",   32'(en),    32'h0);
        chk("rst_fd",   32'(fd),    32'h0);
        chk("rst_hseg", 32'(seg_h), 32'(BL));

        // Scan 1234 for two frames; the load on the release edge shows immediately.
        rst_n = 1'b1;
        value = 16'h1234;
        load  = 1'b1;
        scan("scan", 1, {G1, G2, G3, G4}, {G1, G2, G3, G4});
        load  = 1'b0;
        scan("scan", 31, {G1, G2, G3, G4}, {G1, G2, G3, G4});

        // Hex letters blank without HEX_MODE, A/F with it.
        value = 16'h00AF;
        load  = 1'b1;
        scan("hex", 1, {ZU, ZU, BL, BL}, {ZU, ZU, GA, GF});
        load  = 1'b0;
        scan("hex", 15, {ZU, ZU, BL, BL}, {ZU, ZU, GA, GF});

        // Leading zeros.
        value = 16'h0050;
        load  = 1'b1;
        scan("lz", 1, {ZU, ZU, G5, G0}, {ZU, ZU, G5, G0});
        load  = 1'b0;
        scan("lz", 15, {ZU, ZU, G5, G0}, {ZU, ZU, G5, G0});

        // Blink across one full period: 32 dark, 32 lit (8 of those lit cycles are guard).
        blink   = 1'b1;
        lit_cnt = 0;
        fd_cnt  = 0;
        for (int c = 0; c < 64; c++) begin
            scan("blink", 1, {ZU, ZU, G5, G0}, {ZU, ZU, G5, G0});
            lit_cnt += (en != 4'b0000) ? 1 : 0;
            fd_cnt  += fd ? 1 : 0;
        end
        chk("blink_lit_cycles", 32'(lit_cnt), 32'd24);
        chk("blink_frame_done", 32'(fd_cnt),  32'd4);
        scan("blink_more", 8, {ZU, ZU, G5, G0}, {ZU, ZU, G5, G0});
        blink = 1'b0;
        scan("unblink", 16, {ZU, ZU, G5, G0}, {ZU, ZU, G5, G0});

        // Load on the prescaler wrap cycle lands in the new slot.
        guard = 0;
        while (tb_p != 3 && guard < 8) begin
            scan("pre_wrap", 1, {ZU, ZU, G5, G0}, {ZU, ZU, G5, G0});
            guard++;
        end
        chk("wrap_reached", 32'(tb_p), 32'd3);
        value = 16'h9999;
        load  = 1'b1;
        scan("wrap_guard", 1, {G9, G9, G9, G9}, {G9, G9, G9, G9});
        load  = 1'b0;
        scan("wrap_first", 1, {G9, G9, G9, G9}, {G9, G9, G9, G9});
        chk("wrap_first_glyph", 32'(seg), 32'(G9));

        // Reset during digit 2.
        guard = 0;
        while (!(tb_i == 2 && tb_p == 2) && guard < 20) begin
            scan("pre_rst", 1, {G9, G9, G9, G9}, {G9, G9, G9, G9});
            guard++;
        end
        chk("rst_point", 32'(tb_i), 32'd2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tb_p  = 0;
        tb_i  = 0;
        tb_f  = 0;
        tb_ph = 1'b0;
        chk("mid_rst_seg", 32'(seg), 32'(BL));
        chk("mid_rst_en",  32'(en),  32'h0);
        chk("mid_rst_fd",  32'(fd),  32'h0);
        rst_n = 1'b1;
        scan("post_rst", 1, {ZU, ZU, ZU, G0}, {ZU, ZU, ZU, G0});
        chk("post_rst_digit0", 32'(seg), 32'(G0));
        scan("post_rst", 15, {ZU, ZU, ZU, G0}, {ZU, ZU, ZU, G0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
